led_gpio_ctrl: RTL and testbench

Parametrised LED output controller for the MicroBlaze SoC. It replaces the fixed 8-bit GPIO LED output with a register-programmable driver. The driver supports four display modes: direct, blink, chase (rotate) and PWM dim. It sits between a simple single-cycle register bus (bridged from the processor's peripheral bus) and the board LED pins.

---
 rtl/led_gpio_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_led_gpio_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_gpio_ctrl.sv
// led_gpio_ctrl: register-programmable LED driver with direct, blink, chase
// and PWM-dim modes behind a single-cycle register bus.
module led_gpio_ctrl #(
  parameter int          N_LED        = 8,
  parameter int          TICK_DIV     = 50000,
  parameter logic [31:0] INIT_PATTERN = 32'h0000_0000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [1:0]       addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             tick,
  output logic [N_LED-1:0] LED_O
);

  localparam int               PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [N_LED-1:0] INIT_LED  = INIT_PATTERN[N_LED-1:0];

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_DUTY   = 2'd3;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_PWM    = 2'd3
  } mode_e;

  // Rotate left by one, MSB wraps into bit 0.
  function automatic logic [N_LED-1:0] rotl1(input logic [N_LED-1:0] v);
    return {v[N_LED-2:0], v[N_LED-1]};
  endfunction

  mode_e            mode_q, mode_d;
  logic [N_LED-1:0] data_q, data_d;
  logic [15:0]      period_q, period_d;
  logic [7:0]       duty_q, duty_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;
  logic [15:0]      per_cnt_q, per_cnt_d;
  logic             phase_q, phase_d;
  logic [N_LED-1:0] shift_q, shift_d;
  logic [7:0]       pwm_q, pwm_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic             wr_ctrl_s;
  logic             wr_data_s;
  logic             mode_chg_s;
  logic [15:0]      per_lim_s;
  logic             event_s;
  logic             unused_wr_s;

  // High write-data bits carry no register content.
  assign unused_wr_s = ^wr_data[31:16];

  // Write decode, mode-entry detection and period event generation.
  always_comb begin
    wr_ctrl_s  = wr_en && (addr == ADDR_CTRL);
    wr_data_s  = wr_en && (addr == ADDR_DATA);
    mode_chg_s = wr_ctrl_s && (mode_e'(wr_data[1:0]) != mode_q);
    // A PERIOD of 0 behaves as 1, so the last count is PERIOD-1 clamped at 0.
    if (period_q == 16'd0) begin
      per_lim_s = 16'd0;
    end else begin
      per_lim_s = period_q - 16'd1;
    end
    // >= (not ==) so a PERIOD shrunk below the running count wraps next tick.
    event_s = tick_q && (per_cnt_q >= per_lim_s);
  end

  // Register file next state: a write lands at the strobe edge.
  always_comb begin
    mode_d   = mode_q;
    data_d   = data_q;
    period_d = period_q;
    duty_d   = duty_q;
    if (wr_en) begin
      case (addr)
        ADDR_CTRL:   mode_d   = mode_e'(wr_data[1:0]);
        ADDR_DATA:   data_d   = wr_data[N_LED-1:0];
        ADDR_PERIOD: period_d = wr_data[15:0];
        ADDR_DUTY:   duty_d   = wr_data[7:0];
        default:     mode_d   = mode_q;
      endcase
    end else begin
      mode_d = mode_q;
    end
  end

  // Timebase: prescaler with registered tick, then the period counter.
  always_comb begin
    presc_d   = presc_q;
    per_cnt_d = per_cnt_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
    // tick_q is high exactly while presc_q sits at its terminal count.
    tick_d = (presc_d == PRESC_MAX);
    if (mode_chg_s) begin
      per_cnt_d = 16'd0;
    end else if (event_s) begin
      per_cnt_d = 16'd0;
    end else if (tick_q) begin
      per_cnt_d = per_cnt_q + 16'd1;
    end else begin
      per_cnt_d = per_cnt_q;
    end
  end

  // Pattern state (phase, chase shifter, PWM counter) and next LED value.
  always_comb begin
    phase_d = phase_q;
    shift_d = shift_q;
    pwm_d   = pwm_q + 8'd1;
    led_d   = '0;
    if (mode_chg_s) begin
      phase_d = 1'b1;
    end else if (event_s && (mode_q == MODE_BLINK)) begin
      phase_d = ~phase_q;
    end else begin
      phase_d = phase_q;
    end
    // A DATA load beats a coincident rotate.
    if (mode_chg_s) begin
      shift_d = data_q;
    end else if (wr_data_s && (mode_q == MODE_CHASE)) begin
      shift_d = wr_data[N_LED-1:0];
    end else if (event_s && (mode_q == MODE_CHASE)) begin
      shift_d = rotl1(shift_q);
    end else begin
      shift_d = shift_q;
    end
    case (mode_q)
      MODE_DIRECT: led_d = data_q;
      MODE_BLINK:  led_d = phase_q ? data_q : '0;
      MODE_CHASE:  led_d = shift_q;
      MODE_PWM:    led_d = (pwm_q < duty_q) ? data_q : '0;
      default:     led_d = '0;
    endcase
  end

  // Read port: capture the pre-write register value on the strobe edge.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    if (rd_en) begin
      case (addr)
        ADDR_CTRL:   rd_data_d = 32'(mode_q);
        ADDR_DATA:   rd_data_d = 32'(data_q);
        ADDR_PERIOD: rd_data_d = {16'd0, period_q};
        ADDR_DUTY:   rd_data_d = {24'd0, duty_q};
        default:     rd_data_d = 32'd0;
      endcase
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      mode_q     <= MODE_DIRECT;
      data_q     <= INIT_LED;
      period_q   <= 16'd0;
      duty_q     <= 8'd0;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      per_cnt_q  <= 16'd0;
      phase_q    <= 1'b1;
      shift_q    <= INIT_LED;
      pwm_q      <= 8'd0;
      led_q      <= '0;
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      data_q     <= data_d;
      period_q   <= period_d;
      duty_q     <= duty_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      per_cnt_q  <= per_cnt_d;
      phase_q    <= phase_d;
      shift_q    <= shift_d;
      pwm_q      <= pwm_d;
      led_q      <= led_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign tick     = tick_q;
  assign LED_O    = led_q;

endmodule

// File: tb/tb_led_gpio_ctrl.sv
// Scoreboard bench for led_gpio_ctrl: stimulus pushes expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_led_gpio_ctrl;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_DATA = 2'd1;
  localparam logic [1:0] A_PER  = 2'd2;
  localparam logic [1:0] A_DUTY = 2'd3;

  localparam int K_LED  = 0;  // compare LED_O
  localparam int K_LEDT = 1;  // compare LED_O and tick
  localparam int K_RST  = 2;  // all outputs at reset value
  localparam int K_TMO  = 3;  // wait bound expired

  typedef struct {
    int         kind;
    logic [7:0] led;
    logic       tk;
    int         tag;
  } exp_t;

  logic        CLK;
  logic        RESET;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        tick;
  logic [7:0]  LED_O;

  exp_t        chk_q[$];
  logic [31:0] rd_q[$];
  int          pwm_q[$];

  int n_chk = 0;
  int n_fail = 0;
  logic done = 1'b0;
  logic final_done = 1'b0;

  logic [7:0] chase_exp [4];

  led_gpio_ctrl #(
    .N_LED       (8),
    .TICK_DIV    (4),
    .INIT_PATTERN(32'h0000_00AA)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .tick    (tick),
    .LED_O   (LED_O)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_chk(input int kind, input logic [7:0] led, input logic tk, input int tag);
    exp_t e;
    e.kind = kind;
    e.led  = led;
    e.tk   = tk;
    e.tag  = tag;
    chk_q.push_back(e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] expv);
    addr = a; rd_en = 1'b1;
    rd_q.push_back(expv);
    step();
    rd_en = 1'b0;
  endtask

  task automatic rw_same(input logic [1:0] a, input logic [31:0] d, input logic [31:0] old_v);
    addr = a; wr_data = d; wr_en = 1'b1; rd_en = 1'b1;
    rd_q.push_back(old_v);
    step();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  // Step until tick is seen high (returns just after that edge), bounded.
  task automatic sync_tick(input int tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < 16);
    if (tick !== 1'b1) push_chk(K_TMO, 8'h00, 1'b0, tag);
  endtask

  // Monitor: pops expectations and compares, PWM window counting, final drain.
  always @(negedge CLK) begin : monitor
    exp_t        e;
    logic [31:0] rexp;
    static logic win_active = 1'b0;
    static int   win_left = 0;
    static int   win_cnt = 0;
    static int   win_exp = 0;
    if (rd_valid === 1'b1) begin
      n_chk++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_spurious: rd_valid=1 with no read outstanding, rd_data=%h", rd_data);
      end else begin
        rexp = rd_q.pop_front();
        if (rd_data !== rexp) begin
          n_fail++;
          $display("FAIL rd_data: got %h expected %h", rd_data, rexp);
        end
      end
    end
    while (chk_q.size() > 0) begin
      e = chk_q.pop_front();
      n_chk++;
      case (e.kind)
        K_LED: begin
          if (LED_O !== e.led) begin
            n_fail++;
            $display("FAIL led tag=%0d: LED_O=%h expected %h", e.tag, LED_O, e.led);
          end
        end
        K_LEDT: begin
          if (LED_O !== e.led || tick !== e.tk) begin
            n_fail++;
            $display("FAIL led_tick tag=%0d: LED_O=%h tick=%b expected %h tick=%b",
                     e.tag, LED_O, tick, e.led, e.tk);
          end
        end
        K_RST: begin
          if (LED_O !== 8'h00 || tick !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset tag=%0d: LED_O=%h tick=%b rd_valid=%b rd_data=%h expected all zero",
                     e.tag, LED_O, tick, rd_valid, rd_data);
          end
        end
        default: begin
          n_fail++;
          $display("FAIL timeout tag=%0d: tick not seen within bound, got tick=%b expected 1", e.tag, tick);
        end
      endcase
    end
    if (!win_active && pwm_q.size() > 0) begin
      win_exp    = pwm_q.pop_front();
      win_active = 1'b1;
      win_left   = 256;
      win_cnt    = 0;
    end
    if (win_active) begin
      if (LED_O === 8'hFF) win_cnt++;
      win_left--;
      if (win_left == 0) begin
        win_active = 1'b0;
        n_chk++;
        if (win_cnt != win_exp) begin
          n_fail++;
          $display("FAIL pwm_window: on-cycles %0d expected %0d", win_cnt, win_exp);
        end
      end
    end
    if (done && !final_done) begin
      n_chk++;
      if (rd_q.size() != 0 || pwm_q.size() != 0 || win_active) begin
        n_fail++;
        $display("FAIL drain: pending reads %0d windows %0d expected 0 0", rd_q.size(), pwm_q.size());
      end
      final_done = 1'b1;
    end
  end

  initial begin
    chase_exp[0] = 8'h81; chase_exp[1] = 8'h03; chase_exp[2] = 8'h06; chase_exp[3] = 8'h0C;
    RESET = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 2'd0; wr_data = 32'h0;

    // Reset and direct mode.
    for (int i = 0; i < 3; i++) begin
      step();
      push_chk(K_RST, 8'h00, 1'b0, i);
    end
    RESET = 1'b1;
    step();
    push_chk(K_LED, 8'hAA, 1'b0, 10);
    rd(A_DATA, 32'h0000_00AA);
    rd(A_CTRL, 32'h0000_0000);
    rd(A_PER, 32'h0000_0000);

    // Blink, PERIOD=2: 8 cycles on, 8 off; tick every 4 cycles.
    rw_same(A_DATA, 32'h0000_000F, 32'h0000_00AA);
    rd(A_DATA, 32'h0000_000F);
    wr(A_PER, 32'hFFFF_0002);
    rd(A_PER, 32'h0000_0002);
    sync_tick(100);
    wr(A_CTRL, 32'hFFFF_FFF1);
    for (int i = 0; i < 32; i++) begin
      step();
      push_chk(K_LEDT, ((i / 8) % 2 == 0) ? 8'h0F : 8'h00, ((i + 2) % 4) == 0, 100 + i);
    end
    rd(A_CTRL, 32'h0000_0001);

    // Chase, PERIOD=1: rotate every tick; DATA write on an event wins.
    wr(A_DATA, 32'h0000_0081);
    wr(A_PER, 32'h0000_0001);
    sync_tick(200);
    wr(A_CTRL, 32'h0000_0002);
    for (int i = 0; i < 16; i++) begin
      step();
      push_chk(K_LED, chase_exp[i / 4], 1'b0, 200 + i);
    end
    sync_tick(250);
    wr(A_DATA, 32'h0000_0001);
    for (int i = 0; i < 8; i++) begin
      step();
      push_chk(K_LED, (i < 4) ? 8'h01 : 8'h02, 1'b0, 250 + i);
    end

    // PWM: on-cycles per 256-cycle window equal DUTY.
    wr(A_DATA, 32'h0000_00FF);
    wr(A_DUTY, 32'hABCD_EF40);
    rd(A_DUTY, 32'h0000_0040);
    wr(A_CTRL, 32'h0000_0003);
    step();
    pwm_q.push_back(64);
    repeat (260) step();
    wr(A_DUTY, 32'h0000_0000);
    step();
    pwm_q.push_back(0);
    repeat (260) step();
    wr(A_DUTY, 32'h0000_00FF);
    step();
    pwm_q.push_back(255);
    repeat (260) step();

    // Blink with PERIOD=0: toggle on every tick.
    wr(A_PER, 32'h0000_0000);
    rd(A_PER, 32'h0000_0000);
    sync_tick(300);
    wr(A_CTRL, 32'h0000_0001);
    for (int i = 0; i < 16; i++) begin
      step();
      push_chk(K_LED, ((i / 4) % 2 == 0) ? 8'hFF : 8'h00, 1'b0, 300 + i);
    end

    // PERIOD shrunk from 100 to 2 with the counter at 50: event next tick.
    wr(A_PER, 32'h0000_0064);
    wr(A_CTRL, 32'h0000_0000);
    sync_tick(400);
    wr(A_CTRL, 32'h0000_0001);
    for (int k = 0; k < 50; k++) sync_tick(401);
    wr(A_PER, 32'h0000_0002);
    for (int i = 0; i < 12; i++) begin
      step();
      push_chk(K_LED, (i < 4) ? 8'hFF : 8'h00, 1'b0, 410 + i);
    end

    // Reset in the middle of chase.
    wr(A_DATA, 32'h0000_0081);
    wr(A_CTRL, 32'h0000_0002);
    repeat (5) step();
    rd(A_DATA, 32'h0000_0081);
    RESET = 1'b0;
    step();
    push_chk(K_RST, 8'h00, 1'b0, 500);
    RESET = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      push_chk(K_LEDT, 8'hAA, (i == 3), 500 + i);
    end
    rd(A_CTRL, 32'h0000_0000);
    rd(A_DATA, 32'h0000_00AA);

    repeat (3) step();
    done = 1'b1;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
